pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 63 ++++++
 tb/tb_pipe_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and parameter defaults for the pipeline controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: read-after-write hazard check of ID sources against EXE/MEM destinations.
module hazard_detect (
  input  logic       forward_en,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       two_src,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read,
  input  logic [3:0] exe_dest,
  input  logic       mem_wb_en,
  input  logic [3:0] mem_dest,
  output logic       hazard
);
  logic e1, e2, m1, m2;
  assign e1 = exe_wb_en && exe_dest == src1;
  assign e2 = two_src && exe_wb_en && exe_dest == src2;
  assign m1 = mem_wb_en && mem_dest == src1;
  assign m2 = two_src && mem_wb_en && mem_dest == src2;
  // with forwarding only a load in EXE cannot be bypassed in time
  assign hazard = forward_en ? exe_mem_read && (e1 || e2) : e1 || e2 || m1 || m2;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush control with memory-wait FSM, timeout error and performance counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic hazard, mem_stall;
  hazard_detect u_haz (
    .forward_en(forward_en), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard(hazard)
  );
  always_comb begin
    state_nx = state;
    mem_stall = state == ERR || (state == RUN ? mem_req && !mem_ready : !mem_ready);
    if (state == RUN && mem_req && !mem_ready) state_nx = MEM_WAIT;
    else if (state == MEM_WAIT) state_nx = mem_ready ? RUN : wait_cnt == WW'(TIMEOUT - 1) ? ERR : MEM_WAIT;
    pc_freeze = rst && (mem_stall || (!branch_taken && hazard));
    if_freeze = pc_freeze;
    if_flush = rst && !mem_stall && branch_taken;
    id_flush = rst && !mem_stall && (branch_taken || hazard);
    pipe_freeze = rst && mem_stall;
    mem_timeout = state == ERR;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wait_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= state == MEM_WAIT ? wait_cnt + 1'b1 : '0;
      stall_cnt <= stall_cnt + CNT_W'(pc_freeze && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(if_flush && !(&flush_cnt));
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
  localparam int TO = 8;
  localparam int SAT = 15;
  logic clk = 0, rst = 0;
  logic forward_en, two_src, exe_wb_en, exe_mem_read, mem_wb_en, branch_taken, mem_req, mem_ready;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
  bit go = 0;
  int m_wait, m_stall, m_flush;
  bit m_err, e_pc, e_ifl, e_idf, e_pipe, haz, ms;
  always #5 clk = ~clk;
  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze), .if_freeze(if_freeze),
    .if_flush(if_flush), .id_flush(id_flush), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic bit ref_haz();
    bit x1 = exe_wb_en && exe_dest == src1, x2 = two_src && exe_wb_en && exe_dest == src2;
    bit y1 = mem_wb_en && mem_dest == src1, y2 = two_src && mem_wb_en && mem_dest == src2;
    return forward_en ? exe_mem_read && (x1 || x2) : x1 || x2 || y1 || y2;
  endfunction
  // model state: m_wait < 0 means not waiting on memory, otherwise cycles already spent waiting
  always @(negedge clk) if (go) begin
    if (!rst) begin
      m_wait = -1; m_err = 0; m_stall = 0; m_flush = 0;
    end
    haz = ref_haz();
    ms = m_err || (m_wait < 0 ? mem_req && !mem_ready : !mem_ready);
    e_pc = rst && (ms || (!branch_taken && haz));
    e_ifl = rst && !ms && branch_taken;
    e_idf = rst && !ms && (branch_taken || haz);
    e_pipe = rst && ms;
    chk("pc_freeze", pc_freeze, e_pc);
    chk("if_freeze", if_freeze, e_pc);
    chk("if_flush", if_flush, e_ifl);
    chk("id_flush", id_flush, e_idf);
    chk("pipe_freeze", pipe_freeze, e_pipe);
    chk("mem_timeout", mem_timeout, m_err);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    if (rst) begin
      m_stall = m_stall + e_pc > SAT ? SAT : m_stall + e_pc;
      m_flush = m_flush + e_ifl > SAT ? SAT : m_flush + e_ifl;
      if (!m_err) begin
        if (m_wait < 0) m_wait = mem_req && !mem_ready ? 0 : -1;
        else if (mem_ready) m_wait = -1;
        else if (m_wait == TO - 1) begin m_err = 1; m_wait = -1; end
        else m_wait++;
      end
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle();
    {forward_en, two_src, exe_wb_en, exe_mem_read, mem_wb_en, branch_taken, mem_req, mem_ready} = '0;
    {src1, src2, exe_dest, mem_dest} = '0;
  endtask
  task automatic set_haz();
    forward_en = 0; exe_wb_en = 1; exe_dest = 3; src1 = 3;
  endtask
  task automatic do_reset(); rst = 0; tick(); rst = 1; endtask
  initial begin
    idle();
    @(posedge clk); #1; go = 1;
    @(negedge clk);
    chk("rst_pc_freeze", pc_freeze, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    tick(); rst = 1;
    set_haz();
    @(negedge clk);
    chk("haz_pc_freeze", pc_freeze, 1);
    chk("haz_if_freeze", if_freeze, 1);
    chk("haz_id_flush", id_flush, 1);
    tick(); idle();
    @(negedge clk); chk("haz_stall_cnt", stall_cnt, 1);
    tick(); set_haz(); forward_en = 1; exe_mem_read = 0;
    @(negedge clk); chk("fwd_alu_no_stall", pc_freeze, 0);
    tick(); exe_mem_read = 1;
    @(negedge clk); chk("fwd_load_stall", pc_freeze, 1);
    tick(); idle(); set_haz(); branch_taken = 1;
    @(negedge clk);
    chk("br_if_flush", if_flush, 1);
    chk("br_id_flush", id_flush, 1);
    chk("br_pc_freeze", pc_freeze, 0);
    tick(); idle();
    @(negedge clk); chk("br_flush_cnt", flush_cnt, 1);
    tick(); mem_req = 1; branch_taken = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("memw_pipe_freeze", pipe_freeze, 1);
      chk("memw_no_flush", if_flush, 0);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("memw_done_pipe_freeze", pipe_freeze, 0);
    chk("memw_deferred_flush", if_flush, 1);
    tick(); idle();
    do_reset(); set_haz();
    repeat (20) tick();
    idle();
    @(negedge clk); chk("stall_cnt_sat", stall_cnt, 15);
    tick(); do_reset(); mem_req = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 8) chk("to_not_yet", mem_timeout, 0);
      if (k == 9) chk("to_err", mem_timeout, 1);
      tick();
    end
    mem_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("err_held", mem_timeout, 1);
      chk("err_freeze", pipe_freeze, 1);
      tick();
    end
    @(negedge clk); #2; rst = 0; #1;
    chk("async_rst_timeout", mem_timeout, 0);
    chk("async_rst_freeze", pipe_freeze, 0);
    tick(); tick(); rst = 1;
    for (int seg = 0; seg < 4; seg++)
      for (int i = 0; i < 150; i++) begin
        rst = $urandom_range(0, 49) != 0;
        forward_en = 1'($urandom_range(0, 1));
        two_src = 1'($urandom_range(0, 1));
        exe_wb_en = 1'($urandom_range(0, 1));
        exe_mem_read = 1'($urandom_range(0, 1));
        mem_wb_en = 1'($urandom_range(0, 1));
        branch_taken = $urandom_range(0, 5) == 0;
        mem_req = $urandom_range(0, 3) == 0;
        mem_ready = seg == 2 ? $urandom_range(0, 11) == 0 : 1'($urandom_range(0, 1));
        src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
        exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
        tick();
      end
    idle(); rst = 1;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
